// File: rtl/sprite_frame_writer.sv
// Write side of the sprite/frame RAM: streams 2-bit pixels into a rectangle
// at base_addr with row pitch stride, driving the RAM write port from registers.
// Latency: pixel accepted in cycle N is written in cycle N+1. Backpressure: in_ready = busy (RUN state).
//
// Ports:
//   Clk, Reset                 clock, asynchronous active-high reset
//   start                      1-cycle pulse, latches the rectangle (ignored unless idle)
//   base_addr, stride          top-left address and row pitch
//   rect_w, rect_h             rectangle size in pixels / rows
//   in_data, in_valid/in_ready pixel stream (valid/ready handshake)
//   we, write_address, data_In RAM write port (registered)
//   busy, done, oob            status: running, end-of-rectangle pulse, sticky out-of-bounds
//
// Build option: define TRANSPARENT_SKIP_EN to treat pixel value 0 as transparent
// (consumed and counted, but never written).

module sprite_frame_writer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 2,
    parameter int DEPTH  = 36001,
    parameter int DIM_W  = 9
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [DIM_W-1:0]  rect_w,
    input  logic [DIM_W-1:0]  rect_h,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] data_In,
    output logic              busy,
    output logic              done,
    output logic              oob
);

    // One extra bit so DEPTH itself (which may equal 2^ADDR_W) is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] row_base;
    logic [DIM_W-1:0]  w_q;
    logic [DIM_W-1:0]  h_q;
    logic [DIM_W-1:0]  col;
    logic [DIM_W-1:0]  row;

    logic              accept;
    logic              last_col;
    logic              last_row;
    logic              in_bounds;
    logic              skip_pix;
    logic [ADDR_W-1:0] addr;

    assign in_ready = (state == S_RUN);
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);
    assign accept   = in_valid & in_ready;

    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign addr      = row_base + ADDR_W'(col);
    assign last_col  = (col == w_q - 1'b1);
    assign last_row  = (row == h_q - 1'b1);
    assign in_bounds = ({1'b0, addr} < DEPTH_L);

`ifdef TRANSPARENT_SKIP_EN
    assign skip_pix = (in_data == '0);
`else
    assign skip_pix = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    // Empty rectangle finishes without ever opening the stream.
                    state_nxt = ((rect_w != '0) && (rect_h != '0)) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (accept && last_col && last_row) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= S_IDLE;
            we            <= 1'b0;
            write_address <= '0;
            data_In       <= '0;
            oob           <= 1'b0;
            stride_q      <= '0;
            row_base      <= '0;
            w_q           <= '0;
            h_q           <= '0;
            col           <= '0;
            row           <= '0;
        end else begin
            state <= state_nxt;

            // Suppressed pixels (out of bounds or transparent) still advance
            // the counters below; only the write strobe is withheld.
            we <= accept & in_bounds & ~skip_pix;
            if (accept) begin
                write_address <= addr;
                data_In       <= in_data;
            end

            if ((state == S_IDLE) && start) begin
                stride_q <= stride;
                w_q      <= rect_w;
                h_q      <= rect_h;
                row_base <= base_addr;
                col      <= '0;
                row      <= '0;
                oob      <= 1'b0;
            end else if (accept) begin
                if (!in_bounds) begin
                    oob <= 1'b1;
                end
                if (last_col) begin
                    col      <= '0;
                    row      <= row + 1'b1;
                    row_base <= row_base + stride_q;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_frame_writer.sv
`timescale 1ns/1ps
module tb_sprite_frame_writer;

    localparam int DEPTH = 36001;
`ifdef TRANSPARENT_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] stride;
    logic [8:0]  rect_w;
    logic [8:0]  rect_h;
    logic [1:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        we;
    logic [15:0] write_address;
    logic [1:0]  data_In;
    logic        busy;
    logic        done;
    logic        oob;

    sprite_frame_writer dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .base_addr(base_addr), .stride(stride), .rect_w(rect_w), .rect_h(rect_h),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .we(we), .write_address(write_address), .data_In(data_In),
        .busy(busy), .done(done), .oob(oob)
    );

    always #5 Clk = ~Clk;

    int     tests = 0;
    int     fails = 0;
    longint cyc_n = 0;
    longint start_cyc = 0;

    always @(posedge Clk) cyc_n++;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic bit is_skipped(input logic [1:0] d);
        return SKIP && (d == 2'd0);
    endfunction

    // Reference model: tracks only "job active", pixel index k and the latched
    // rectangle; each pixel's address is derived directly from k.
    bit          m_active = 0;
    bit          m_done   = 0;
    bit          m_oob    = 0;
    bit          e_we     = 0;
    longint      m_k      = 0;
    longint      m_w      = 0;
    longint      m_h      = 0;
    longint      m_base   = 0;
    longint      m_stride = 0;
    logic [15:0] e_addr   = '0;
    logic [1:0]  e_data   = '0;

    logic [15:0] log_addr[$];
    logic [1:0]  log_data[$];
    longint      log_cyc[$];
    longint      done_cyc[$];
    logic [1:0]  pix[$];

    always @(negedge Clk) begin
        longint a;
        bit     inb;
        bit     nxt_we;
        bit     nxt_done;
        if (Reset) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_we", we, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_oob", oob, 0);
            chk("rst_addr", write_address, 0);
            chk("rst_data", data_In, 0);
            m_active = 0; m_done = 0; m_oob = 0; e_we = 0; m_k = 0;
        end else begin
            chk("in_ready", in_ready, m_active);
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("we", we, e_we);
            chk("oob", oob, m_oob);
            if (e_we) begin
                chk("write_address", write_address, e_addr);
                chk("data_In", data_In, e_data);
            end
            if (we === 1'b1) begin
                log_addr.push_back(write_address);
                log_data.push_back(data_In);
                log_cyc.push_back(cyc_n);
            end
            if (done === 1'b1) done_cyc.push_back(cyc_n);

            // Predict the outputs after the coming clock edge.
            nxt_we = 0;
            nxt_done = 0;
            if (m_active) begin
                if (in_valid) begin
                    a = (m_base + (m_k / m_w) * m_stride + (m_k % m_w)) % 65536;
                    inb = (a < DEPTH);
                    if (!inb) m_oob = 1;
                    nxt_we = inb && !is_skipped(in_data);
                    e_addr = a[15:0];
                    e_data = in_data;
                    m_k++;
                    if (m_k == m_w * m_h) begin
                        m_active = 0;
                        nxt_done = 1;
                    end
                end
            end else if (!m_done && start) begin
                m_base = base_addr; m_stride = stride; m_w = rect_w; m_h = rect_h;
                m_k = 0; m_oob = 0;
                if (m_w == 0 || m_h == 0) nxt_done = 1;
                else m_active = 1;
            end
            m_done = nxt_done;
            e_we = nxt_we;
        end
    end

    // Called at posedge+1 with the writer idle. mode 0: in_valid always,
    // 1: toggling, 2: random valid plus stray start pulses.
    task automatic run_job(input logic [15:0] b, input logic [15:0] s,
                           input int w, input int h, input int mode);
        int n;
        int idx;
        int guard;
        n = w * h; idx = 0; guard = 0;
        log_addr.delete(); log_data.delete(); log_cyc.delete(); done_cyc.delete();
        base_addr = b; stride = s; rect_w = w[8:0]; rect_h = h[8:0];
        start = 1'b1; in_valid = 1'($urandom); in_data = 2'($urandom);
        start_cyc = cyc_n;
        @(posedge Clk); #1;
        start = 1'b0;
        if (mode == 2) begin
            base_addr = 16'($urandom); stride = 16'($urandom);
            rect_w = 9'($urandom_range(0, 8)); rect_h = 9'($urandom_range(0, 8));
        end
        while (idx < n && guard < 2000) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (guard % 2 == 0);
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            in_data = pix[idx];
            if (mode == 2) start = ($urandom_range(0, 7) == 0);
            @(negedge Clk);
            if (in_valid && in_ready) idx++;
            @(posedge Clk); #1;
            guard++;
        end
        start = 1'b0; in_valid = 1'b0;
        if (idx < n) chk("job_timeout_pixels", idx, n);
        if (mode == 2) begin
            // Writer is in its done cycle: start and in_valid must both be ignored.
            start = 1'b1; in_valid = 1'b1;
            @(posedge Clk); #1;
            start = 1'b0; in_valid = 1'b0;
        end
        repeat (3) @(posedge Clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ea[6];
        int ed[6];
        Reset = 1'b1; start = 1'b0; base_addr = '0; stride = '0;
        rect_w = '0; rect_h = '0; in_data = '0; in_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Basic 3x2 rectangle, continuous stream.
        ea = '{100, 101, 102, 420, 421, 422};
        ed = '{1, 2, 3, 1, 2, 3};
        pix.delete();
        foreach (ed[i]) pix.push_back(2'(ed[i]));
        run_job(16'd100, 16'd320, 3, 2, 0);
        chk("basic_nwrites", log_addr.size(), 6);
        if (log_addr.size() == 6) begin
            foreach (ea[i]) begin
                chk("basic_addr", log_addr[i], ea[i]);
                chk("basic_data", log_data[i], ed[i]);
                chk("basic_cycle", log_cyc[i], start_cyc + 2 + i);
            end
            chk("basic_ndone", done_cyc.size(), 1);
            if (done_cyc.size() == 1) chk("basic_done_with_last", done_cyc[0], log_cyc[5]);
        end

        // Same rectangle, in_valid toggling: one write every other cycle.
        run_job(16'd100, 16'd320, 3, 2, 1);
        chk("toggle_nwrites", log_addr.size(), 6);
        if (log_addr.size() == 6) begin
            foreach (ea[i]) begin
                chk("toggle_addr", log_addr[i], ea[i]);
                chk("toggle_cycle", log_cyc[i], start_cyc + 2 + 2 * i);
            end
        end

        // Zero height: done in the cycle after the start cycle, no writes.
        pix.delete();
        run_job(16'd50, 16'd10, 5, 0, 0);
        chk("zero_nwrites", log_addr.size(), 0);
        chk("zero_ndone", done_cyc.size(), 1);
        if (done_cyc.size() == 1) chk("zero_done_cycle", done_cyc[0], start_cyc + 1);

        // Straddling the end of RAM.
        pix.delete();
        pix.push_back(2'd1); pix.push_back(2'd2); pix.push_back(2'd3); pix.push_back(2'd1);
        run_job(16'd35999, 16'd1, 4, 1, 0);
        chk("oob_nwrites", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("oob_addr0", log_addr[0], 35999);
            chk("oob_addr1", log_addr[1], 36000);
        end
        chk("oob_sticky", oob, 1);
        chk("oob_ndone", done_cyc.size(), 1);

        // Transparent pixels.
        pix.delete();
        pix.push_back(2'd0); pix.push_back(2'd3); pix.push_back(2'd0); pix.push_back(2'd2);
        run_job(16'd10, 16'd0, 4, 1, 0);
        if (SKIP) begin
            chk("skip_nwrites", log_addr.size(), 2);
            if (log_addr.size() == 2) begin
                chk("skip_addr0", log_addr[0], 11);
                chk("skip_data0", log_data[0], 3);
                chk("skip_addr1", log_addr[1], 13);
                chk("skip_data1", log_data[1], 2);
            end
        end else begin
            chk("noskip_nwrites", log_addr.size(), 4);
            if (log_addr.size() == 4) begin
                chk("noskip_addr0", log_addr[0], 10);
                chk("noskip_data0", log_data[0], 0);
                chk("noskip_addr3", log_addr[3], 13);
                chk("noskip_data3", log_data[3], 2);
            end
        end

        // Reset after two accepts of a 4x4 rectangle.
        log_addr.delete(); log_data.delete(); log_cyc.delete(); done_cyc.delete();
        base_addr = 16'd500; stride = 16'd64; rect_w = 9'd4; rect_h = 9'd4;
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 2'd1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_mid_nwrites", log_addr.size(), 1);
        chk("rst_mid_ndone", done_cyc.size(), 0);
        pix.delete();
        pix.push_back(2'd2); pix.push_back(2'd1); pix.push_back(2'd3); pix.push_back(2'd2);
        run_job(16'd2000, 16'd7, 2, 2, 0);
        chk("rst_restart_nwrites", log_addr.size(), SKIP ? 4 : 4);
        if (log_addr.size() > 0) chk("rst_restart_base", log_addr[0], 2000);

        // Randomised rectangles, including wrap-around and out-of-bounds regions.
        for (int j = 0; j < 30; j++) begin
            int w;
            int h;
            logic [15:0] b;
            w = $urandom_range(0, 6);
            h = $urandom_range(0, 4);
            b = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(35990, 36005));
            pix.delete();
            for (int k = 0; k < w * h; k++) pix.push_back(2'($urandom));
            run_job(b, 16'($urandom_range(0, 70000)), w, h, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
